adder_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit ripple-carry adder, built from full-adder cells, between two requesters.
- Each requester presents operands with a valid/ready handshake and receives a registered sum/carry response with its own valid/ready handshake.
- Sits between the switch/operand front ends and the shared adder datapath.
- One operation is in flight at a time.

---
 rtl/adder_share_arb.sv | 119 +++++++++++
 tb/tb_adder_share_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one ripple-carry adder between two requesters.
// One operation in flight; each result is held in a per-requester register until consumed.
module adder_share_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  input  logic             rsp1_ready
);

  typedef enum logic [1:0] {StIdle, StResp0, StResp1} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0, grant1;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum0_q, sum1_q;
  logic             cout0_q, cout1_q;

  // Tie goes to whoever did not win last; reset also masks grants so rst wins over valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Operand mux feeds the single shared full-adder chain.
  always_comb begin
    add_a   = grant1 ? req1_a   : req0_a;
    add_b   = grant1 ? req1_b   : req0_b;
    add_cin = grant1 ? req1_cin : req0_cin;
    carry    = '0;
    add_sum  = '0;
    carry[0] = add_cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      add_sum[i]   = add_a[i] ^ add_b[i] ^ carry[i];
      carry[i+1]   = (add_a[i] & add_b[i]) | (add_a[i] & carry[i]) | (add_b[i] & carry[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (grant0) begin
          state_d      = StResp0;
          last_grant_d = 1'b0;
        end else if (grant1) begin
          state_d      = StResp1;
          last_grant_d = 1'b1;
        end
      end
      StResp0: if (rsp0_ready) state_d = StIdle;
      StResp1: if (rsp1_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      sum0_q       <= '0;
      sum1_q       <= '0;
      cout0_q      <= 1'b0;
      cout1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (grant0) begin
        sum0_q  <= add_sum;
        cout0_q <= carry[WIDTH];
      end
      if (grant1) begin
        sum1_q  <= add_sum;
        cout1_q <= carry[WIDTH];
      end
    end
  end

  assign rsp0_valid = (state_q == StResp0);
  assign rsp1_valid = (state_q == StResp1);
  assign rsp0_sum   = sum0_q;
  assign rsp0_cout  = cout0_q;
  assign rsp1_sum   = sum1_q;
  assign rsp1_cout  = cout1_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: vector table, arbitration, backpressure, reset, sweep.
module tb_adder_share_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_cin, req0_ready, rsp0_valid, rsp0_cout, rsp0_ready;
  logic [3:0] req0_a, req0_b, rsp0_sum;
  logic       req1_valid, req1_cin, req1_ready, rsp1_valid, rsp1_cout, rsp1_ready;
  logic [3:0] req1_a, req1_b, rsp1_sum;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       c;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  adder_share_arb #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_sum   (rsp0_sum),
    .rsp0_cout  (rsp0_cout),
    .rsp0_ready (rsp0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_sum   (rsp1_sum),
    .rsp1_cout  (rsp1_cout),
    .rsp1_ready (rsp1_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    #1;
    check("ready_during_rst", int'(req0_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("rst_rsp0_valid", int'(rsp0_valid), 0);
    check("rst_rsp1_valid", int'(rsp1_valid), 0);
    check("rst_rsp0_sum", int'(rsp0_sum), 0);
    check("rst_rsp1_cout", int'(rsp1_cout), 0);
    rst = 1'b0;
  endtask

  // One op from requester k with rsp_ready held high; leaves the bench at a negedge in IDLE.
  task automatic single_op(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic cin, input logic [3:0] es, input logic ec);
    @(negedge clk);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (k == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end
    #1;
    check("op_ready", int'(k == 0 ? req0_ready : req1_ready), 1);
    check("op_both_ready", int'(req0_ready & req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("op_rsp_valid", int'(k == 0 ? rsp0_valid : rsp1_valid), 1);
    check("op_other_rsp_valid", int'(k == 0 ? rsp1_valid : rsp0_valid), 0);
    check("op_sum", int'(k == 0 ? rsp0_sum : rsp1_sum), int'(es));
    check("op_cout", int'(k == 0 ? rsp0_cout : rsp1_cout), int'(ec));
    @(negedge clk);
    #1;
    check("op_rsp_done", int'(rsp0_valid | rsp1_valid), 0);
  endtask

  initial begin
    vecs[0] = '{k: 1, a: 4'd15, b: 4'd1,  cin: 1'b0, s: 4'd0,  c: 1'b1};
    vecs[1] = '{k: 1, a: 4'd15, b: 4'd15, cin: 1'b1, s: 4'd15, c: 1'b1};
    vecs[2] = '{k: 0, a: 4'd0,  b: 4'd0,  cin: 1'b0, s: 4'd0,  c: 1'b0};
    vecs[3] = '{k: 0, a: 4'd10, b: 4'd5,  cin: 1'b1, s: 4'd0,  c: 1'b1};
    vecs[4] = '{k: 1, a: 4'd8,  b: 4'd7,  cin: 1'b0, s: 4'd15, c: 1'b0};
    vecs[5] = '{k: 0, a: 4'd12, b: 4'd9,  cin: 1'b0, s: 4'd5,  c: 1'b1};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; rsp1_ready = 1'b0;
    do_reset();

    // 3 + 5 with the response held back one cycle.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5; req0_cin = 1'b0;
    #1;
    check("t1_req0_ready", int'(req0_ready), 1);
    check("t1_req1_ready", int'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("t1_rsp0_valid", int'(rsp0_valid), 1);
    check("t1_rsp0_sum", int'(rsp0_sum), 8);
    check("t1_rsp0_cout", int'(rsp0_cout), 0);
    check("t1_rsp1_valid", int'(rsp1_valid), 0);
    @(negedge clk);
    #1;
    check("t1_hold_valid", int'(rsp0_valid), 1);
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t1_consumed", int'(rsp0_valid), 0);
    check("t1_sum_kept", int'(rsp0_sum), 8);

    foreach (vecs[i]) single_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);

    // Continuous requests from both: grants alternate starting with requester 0.
    do_reset();
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_cin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_ready0", int'(req0_ready), int'(i % 4 == 0));
      check("t3_ready1", int'(req1_ready), int'(i % 4 == 2));
      check("t3_rsp0_valid", int'(rsp0_valid), int'(i % 4 == 1));
      check("t3_rsp1_valid", int'(rsp1_valid), int'(i % 4 == 3));
      if (i % 4 == 1) check("t3_rsp0_sum", int'(rsp0_sum), 2);
      if (i % 4 == 3) check("t3_rsp1_sum", int'(rsp1_sum), 4);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd6; req0_cin = 1'b1;
    #1;
    check("t4_req0_ready", int'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd9; req1_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_rsp0_valid", int'(rsp0_valid), 1);
      check("t4_rsp0_sum", int'(rsp0_sum), 14);
      check("t4_rsp0_cout", int'(rsp0_cout), 0);
      check("t4_req1_ready", int'(req1_ready), 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    #1;
    check("t4_req1_accept", int'(req1_ready), 1);
    check("t4_rsp0_done", int'(rsp0_valid), 0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("t4_rsp1_valid", int'(rsp1_valid), 1);
    check("t4_rsp1_sum", int'(rsp1_sum), 2);
    check("t4_rsp1_cout", int'(rsp1_cout), 1);

    // Reset while holding a requester 1 result.
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_ready0_rst", int'(req0_ready), 0);
    check("t5_ready1_rst", int'(req1_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_rsp1_valid", int'(rsp1_valid), 0);
    check("t5_rsp1_sum", int'(rsp1_sum), 0);
    check("t5_rsp1_cout", int'(rsp1_cout), 0);
    check("t5_tie_ready0", int'(req0_ready), 1);
    check("t5_tie_ready1", int'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(negedge clk);

    // Full sweep, alternating the requesting port.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] ref_sum;
          ref_sum = 5'(a + b + c);
          single_op((a + b + c) % 2, 4'(a), 4'(b), 1'(c), ref_sum[3:0], ref_sum[4]);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
